// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I controller and the ALU decoder.
package multi_cycle_controller_pkg;

  // Opcodes (IR[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // ALU operation class, decoded further by the ALU decoder
  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_RTYP = 2'b10;
  localparam logic [1:0] ALUOP_ITYP = 2'b11;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Result mux
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  // ALU operand muxes
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_A     = 2'b10;
  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_4     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_LUI      = 4'd12
  } state_t;

  // Immediate format depends only on the opcode, so it is valid in every state
  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_src_of = IMM_S;
      OP_BRANCH: imm_src_of = IMM_B;
      OP_JAL:    imm_src_of = IMM_J;
      OP_LUI:    imm_src_of = IMM_U;
      default:   imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_controller_branch_unit.sv
// Branch condition from funct3 and the ALU compare flags.
module branch_unit (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lt,
  output logic       taken
);

  // BLTU/BGEU reuse the signed SLT result; 010/011 are not branches
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:          taken = zero;
      3'b001:          taken = ~zero;
      3'b100, 3'b110:  taken = alu_lt;
      3'b101, 3'b111:  taken = ~alu_lt;
      default:         taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Main Moore control FSM for the multi-cycle RV32I core.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
#(
  parameter bit WAIT_MEM = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       alu_lt,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       illegal_instr
);

  state_t r_state;
  state_t w_next;
  logic   w_taken;
  logic   w_mem_done;
  logic   w_pc_write;
  logic   w_mem_write;
  logic   w_ir_write;
  logic   w_reg_write;

  branch_unit u_branch (
    .funct3 (funct3),
    .zero   (zero),
    .alu_lt (alu_lt),
    .taken  (w_taken)
  );

  assign w_mem_done = WAIT_MEM ? mem_ready : 1'b1;
  assign imm_src    = imm_src_of(op);

  // Strobes are gated by reset so nothing writes while rst_n is low,
  // even in the cycle reset lands mid-access
  assign pc_write  = w_pc_write  & rst_n;
  assign mem_write = w_mem_write & rst_n;
  assign ir_write  = w_ir_write  & rst_n;
  assign reg_write = w_reg_write & rst_n;

  // State register, async reset to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_FETCH;
    else        r_state <= w_next;
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next        = r_state;
    w_pc_write    = 1'b0;
    adr_src       = 1'b0;
    w_mem_write   = 1'b0;
    w_ir_write    = 1'b0;
    result_src    = RES_ALUOUT;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_WD;
    alu_op        = ALUOP_ADD;
    w_reg_write   = 1'b0;
    illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        alu_src_b  = SRCB_4;
        result_src = RES_ALU;
        w_ir_write = w_mem_done;
        w_pc_write = w_mem_done;
        if (w_mem_done) w_next = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut as the branch/JAL target
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALRADR;
          OP_LUI:            w_next = S_LUI;
          default: begin
            illegal_instr = 1'b1;
            w_next        = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        w_next    = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (w_mem_done) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe held for the whole stall
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        if (w_mem_done) w_next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_WD;
        alu_op    = ALUOP_RTYP;
        w_next    = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_ITYP;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = SRCA_A;
        alu_src_b  = SRCB_WD;
        alu_op     = ALUOP_BR;
        w_pc_write = w_taken;
        w_next     = S_FETCH;
      end
      S_JAL: begin
        // PC <= ALUOut target while the ALU forms the link OldPC + 4
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_4;
        w_pc_write = 1'b1;
        w_next     = S_ALUWB;
      end
      S_JALRADR: begin
        // Overwrite ALUOut with rs1 + imm, then reuse the JAL path
        alu_src_a = SRCA_A;
        alu_src_b = SRCB_IMM;
        w_next    = S_JAL;
      end
      S_LUI: begin
        result_src  = RES_IMM;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench: per-instruction phase sequences from the ISA-level
// rules, with randomized memory stalls and flags.
module tb_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero, alu_lt, mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;

  int n_checks = 0;
  int n_fail   = 0;

  multi_cycle_controller #(.WAIT_MEM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .alu_lt(alu_lt), .mem_ready(mem_ready), .pc_write(pc_write),
    .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_op(alu_op), .reg_write(reg_write),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, imm, alu_op, reg_write, illegal}
  wire [16:0] act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                     alu_src_b, imm_src, alu_op, reg_write, illegal_instr};

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BRANCH = 9,
                 P_JAL = 10, P_JALRADR = 11, P_LUI = 12;

  function automatic bit is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                     7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
  endfunction

  // Expected control word for one phase of an instruction
  function automatic logic [16:0] model(input int ph, input logic rdy, input logic [6:0] o,
                                        input logic [2:0] f3, input logic z, input logic lt);
    logic pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0, tk = 0;
    logic [1:0] rs = 0, a = 0, b = 0, aop = 0;
    logic [2:0] imm = 3'b000;
    if (o == 7'b0100011) imm = 3'b001;
    else if (o == 7'b1100011) imm = 3'b010;
    else if (o == 7'b1101111) imm = 3'b011;
    else if (o == 7'b0110111) imm = 3'b100;
    case (f3)
      3'd0: tk = z;
      3'd1: tk = !z;
      3'd4, 3'd6: tk = lt;
      3'd5, 3'd7: tk = !lt;
      default: tk = 0;
    endcase
    case (ph)
      P_FETCH:    begin b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      P_DECODE:   begin a = 2'b01; b = 2'b01; ill = !is_legal(o); end
      P_MEMADR:   begin a = 2'b10; b = 2'b01; end
      P_MEMREAD:  adr = 1;
      P_MEMWB:    begin rs = 2'b01; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = 1; end
      P_EXECR:    begin a = 2'b10; aop = 2'b10; end
      P_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b11; end
      P_ALUWB:    rw = 1;
      P_BRANCH:   begin a = 2'b10; aop = 2'b01; pcw = tk; end
      P_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      P_JALRADR:  begin a = 2'b10; b = 2'b01; end
      P_LUI:      begin rs = 2'b11; rw = 1; end
      default: ;
    endcase
    return {pcw, adr, mw, irw, rs, a, b, imm, aop, rw, ill};
  endfunction

  // Runs one instruction starting in FETCH, checking every cycle against the model
  task automatic run_instr(input logic [6:0] iop, input logic [2:0] f3, input logic z,
                           input logic lt, input int stall_pct,
                           output int cycles, output logic last_pcw, output int ill_cnt);
    int path[$];
    logic [16:0] exp;
    logic rdy;
    bit hold;
    int stalls;
    path = {P_FETCH, P_DECODE};
    case (iop)
      7'b0000011: path = {path, P_MEMADR, P_MEMREAD, P_MEMWB};
      7'b0100011: path = {path, P_MEMADR, P_MEMWRITE};
      7'b0110011: path = {path, P_EXECR, P_ALUWB};
      7'b0010011: path = {path, P_EXECI, P_ALUWB};
      7'b1100011: path = {path, P_BRANCH};
      7'b1101111: path = {path, P_JAL, P_ALUWB};
      7'b1100111: path = {path, P_JALRADR, P_JAL, P_ALUWB};
      7'b0110111: path = {path, P_LUI};
      default: ;
    endcase
    cycles = 0; ill_cnt = 0; last_pcw = 0;
    foreach (path[i]) begin
      stalls = 0;
      do begin
        @(negedge clk);
        op = iop; funct3 = f3; zero = z; alu_lt = lt;
        rdy = (stalls >= 3) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        mem_ready = rdy;
        #1;
        exp = model(path[i], rdy, iop, f3, z, lt);
        n_checks++;
        if (act !== exp) begin
          n_fail++;
          $display("FAIL ctrl op=%b f3=%b phase=%0d: got %b want %b", iop, f3, path[i], act, exp);
        end
        cycles++;
        if (illegal_instr) ill_cnt++;
        last_pcw = pc_write;
        hold = (path[i] inside {P_FETCH, P_MEMREAD, P_MEMWRITE}) && !rdy;
        if (hold) stalls++;
      end while (hold);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; mem_ready = 1; op = 7'b0110011; funct3 = 0; zero = 0; alu_lt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({pc_write, ir_write, mem_write, reg_write} !== 4'b0 || alu_src_b !== 2'b10 ||
          result_src !== 2'b10) begin
        n_fail++;
        $display("FAIL reset_hold: strobes=%b b=%b rs=%b want 0000 10 10",
                 {pc_write, ir_write, mem_write, reg_write}, alu_src_b, result_src);
      end
    end
    @(negedge clk); rst_n = 1; #1;
    n_checks++;
    if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: ir_write=%b pc_write=%b want 1 1", ir_write, pc_write);
    end
    mem_ready = 0;  // hold in FETCH for the next task
  endtask

  // Next cycle must be FETCH; checked with the memory stalled so it stays there
  task automatic check_fetch(input string nm);
    @(negedge clk); mem_ready = 0; #1;
    n_checks++;
    if (alu_src_b !== 2'b10 || result_src !== 2'b10 || ir_write !== 1'b0 || reg_write !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_back_to_fetch: b=%b rs=%b irw=%b rw=%b want 10 10 0 0",
               nm, alu_src_b, result_src, ir_write, reg_write);
    end
  endtask

  task automatic test_add();
    int c, ic; logic p;
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, c, p, ic);
    n_checks++;
    if (c !== 4) begin n_fail++; $display("FAIL add_latency: got %0d want 4", c); end
    check_fetch("add");
  endtask

  task automatic test_sw_stall();
    int mw_run = 0;
    @(negedge clk); op = 7'b0100011; funct3 = 3'd2; mem_ready = 1;   // FETCH
    @(negedge clk);                                                 // DECODE
    @(negedge clk);                                                 // MEMADR
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); mem_ready = (i == 2); #1;
      if (mem_write === 1'b1 && adr_src === 1'b1) mw_run++;
    end
    n_checks++;
    if (mw_run !== 3) begin n_fail++; $display("FAIL sw_stall_mem_write: got %0d cycles want 3", mw_run); end
    check_fetch("sw");
  endtask

  task automatic test_branch();
    int c, ic; logic p;
    run_instr(7'b1100011, 3'b000, 1'b1, 1'b0, 0, c, p, ic);
    n_checks++;
    if (p !== 1'b1 || c !== 3) begin n_fail++; $display("FAIL beq_taken: pcw=%b cyc=%0d want 1 3", p, c); end
    run_instr(7'b1100011, 3'b001, 1'b1, 1'b0, 0, c, p, ic);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL bne_not_taken: pcw=%b want 0", p); end
    run_instr(7'b1100011, 3'b101, 1'b0, 1'b0, 0, c, p, ic);
    n_checks++;
    if (p !== 1'b1) begin n_fail++; $display("FAIL bge_taken: pcw=%b want 1", p); end
    run_instr(7'b1100011, 3'b010, 1'b1, 1'b1, 0, c, p, ic);
    n_checks++;
    if (p !== 1'b0) begin n_fail++; $display("FAIL f3_010_never: pcw=%b want 0", p); end
  endtask

  task automatic test_jalr();
    int c, ic; logic p;
    run_instr(7'b1100111, 3'd0, 1'b0, 1'b0, 0, c, p, ic);
    n_checks++;
    if (c !== 5) begin n_fail++; $display("FAIL jalr_latency: got %0d want 5", c); end
  endtask

  task automatic test_illegal();
    int c, ic; logic p;
    run_instr(7'b0000000, 3'd0, 1'b0, 1'b0, 0, c, p, ic);
    n_checks++;
    if (ic !== 1 || c !== 2) begin n_fail++; $display("FAIL illegal_pulse: pulses=%0d cyc=%0d want 1 2", ic, c); end
    check_fetch("illegal");
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk); op = 7'b0100011; mem_ready = 1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); mem_ready = 0; #1;                              // stalled MEMWRITE
    n_checks++;
    if (mem_write !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: mem_write=%b want 1", mem_write); end
    #1 rst_n = 0; #1;
    n_checks++;
    if (mem_write !== 1'b0 || adr_src !== 1'b0 || alu_src_b !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_write: mw=%b adr=%b b=%b want 0 0 10", mem_write, adr_src, alu_src_b);
    end
    @(negedge clk); rst_n = 1; mem_ready = 0; #1;
    n_checks++;
    if (alu_src_b !== 2'b10 || mem_write !== 1'b0 || result_src !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_mid_after: b=%b mw=%b rs=%b want 10 0 10", alu_src_b, mem_write, result_src);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0000000};
    int c, ic; logic p; logic [6:0] o;
    for (int n = 0; n < 300; n++) begin
      o = ($urandom_range(0, 9) == 9) ? 7'($urandom) : ops[$urandom_range(0, 8)];
      run_instr(o, 3'($urandom), 1'($urandom), 1'($urandom), 30, c, p, ic);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sw_stall();
    test_branch();
    test_jalr();
    test_illegal();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
